// File: rtl/adsr_env_gen.sv
// ADSR envelope generator for one voice: gate-driven attack/decay/sustain/release
// stepping of an ENV_W-bit level, with per-stage tick intervals from the register file.
//
// state   | meaning
// IDLE    | no note, env held at 0
// ATTACK  | env rises one step per attack tick up to MAX
// DECAY   | env falls one step per decay tick towards sus_lvl
// SUSTAIN | env follows sus_lvl while gate stays high
// RELEASE | env falls one step per release tick to 0
module adsr_env_gen #(
    parameter int ENV_W       = 7,
    parameter int IVL_W       = 32,
    parameter bit RETRIG_MODE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IVL_W-1:0] a_interval_i,
    input  logic [IVL_W-1:0] d_interval_i,
    input  logic [IVL_W-1:0] r_interval_i,
    input  logic [ENV_W-1:0] sus_lvl_i,
    input  logic             gate_i,
    output logic [ENV_W-1:0] env_out_o,
    output logic [2:0]       stage_o,
    output logic             running_o,
    output logic             eoc_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_e;

    localparam logic [ENV_W-1:0] ENV_MAX  = '1;
    localparam logic [ENV_W-1:0] ENV_ZERO = '0;

    stage_e             stage_q, stage_d;
    logic [ENV_W-1:0]   env_q, env_d;
    logic [IVL_W-1:0]   cnt_q, cnt_d;
    logic               eoc_q, eoc_d;
    logic               g1_q, g2_q, g3_q;

    logic               rise, fall, tick;
    logic [IVL_W-1:0]   ivl_cur;

    // g1 is the metastability stage; edges are detected on the settled g2/g3 pair
    assign rise = g2_q & ~g3_q;
    assign fall = ~g2_q & g3_q;

    always_comb begin
        ivl_cur = '0;
        case (stage_q)
            ST_ATTACK:  ivl_cur = a_interval_i;
            ST_DECAY:   ivl_cur = d_interval_i;
            ST_RELEASE: ivl_cur = r_interval_i;
            default:    ivl_cur = '0;
        endcase
    end

    // >= rather than == so a shortened interval fires at once instead of wrapping
    assign tick = (cnt_q >= ivl_cur);

    always_comb begin
        stage_d = stage_q;
        env_d   = env_q;
        if (rise) begin
            stage_d = ST_ATTACK;
            if (RETRIG_MODE) begin
                env_d = ENV_ZERO;
            end
        end else if (fall && (stage_q == ST_ATTACK || stage_q == ST_DECAY ||
                              stage_q == ST_SUSTAIN)) begin
            stage_d = ST_RELEASE;
        end else begin
            case (stage_q)
                ST_ATTACK: begin
                    if (env_q == ENV_MAX) begin
                        stage_d = ST_DECAY;
                    end else if (tick) begin
                        env_d = env_q + 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (sus_lvl_i != ENV_ZERO && env_q <= sus_lvl_i) begin
                        stage_d = ST_SUSTAIN;
                    end else if (sus_lvl_i == ENV_ZERO && env_q == ENV_ZERO) begin
                        stage_d = ST_IDLE;
                    end else if (tick) begin
                        env_d = env_q - 1'b1;
                    end
                end
                ST_SUSTAIN: begin
                    if (sus_lvl_i == ENV_ZERO) begin
                        stage_d = ST_DECAY;
                    end else begin
                        env_d = sus_lvl_i;
                    end
                end
                ST_RELEASE: begin
                    if (env_q == ENV_ZERO) begin
                        stage_d = ST_IDLE;
                    end else if (tick) begin
                        env_d = env_q - 1'b1;
                    end
                end
                default: begin
                    stage_d = ST_IDLE;
                end
            endcase
        end
    end

    // A rise restarts the attack timing even when already in ATTACK
    always_comb begin
        cnt_d = '0;
        if (rise || stage_d != stage_q) begin
            cnt_d = '0;
        end else if (stage_q == ST_IDLE || stage_q == ST_SUSTAIN) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign eoc_d = (stage_d == ST_IDLE) && (stage_q != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= ST_IDLE;
            env_q   <= '0;
            cnt_q   <= '0;
            eoc_q   <= 1'b0;
            g1_q    <= 1'b0;
            g2_q    <= 1'b0;
            g3_q    <= 1'b0;
        end else begin
            stage_q <= stage_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            eoc_q   <= eoc_d;
            g1_q    <= gate_i;
            g2_q    <= g1_q;
            g3_q    <= g2_q;
        end
    end

    assign env_out_o = env_q;
    assign stage_o   = stage_q;
    assign running_o = (stage_q != ST_IDLE);
    assign eoc_o     = eoc_q;

endmodule
